// File: rtl/bmi_weight_range.sv
// bmi_weight_range
//
// Given an integer height h (metres) and a BMI category c, reports the
// inclusive weight range [w_min, w_max] (kg) whose BMI falls in c, using
// the floor-free definition lo(c)*h^2 <= w < hi(c)*h^2.
//
// The squaring and both bound multiplications share a single shift-add
// datapath:
//   SQR : h^2     8 iterations, one per bit of h
//   MLO : lo*h^2  5 iterations, one per bit of the 5-bit bound
//   MHI : hi*h^2  5 iterations
//
// busy and done are registered copies of the previous state. Each therefore
// appears one edge after the state that causes it:
//   - done rises 19 edges after a valid request is accepted
//   - done rises 1 edge after an invalid request is accepted
//   - busy and done are never high together
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request pulse, sampled only in IDLE
//   height    height in integer metres (0 is invalid)
//   category  0 under, 1 normal, 2 over, 3 obese; 4..255 invalid
//   busy      request in progress
//   done      one-cycle completion pulse
//   w_min     smallest weight in the category, saturated to 255
//   w_max     largest weight in the category, saturated to 255
//   range_ok  saturated range is non-empty
//   error     last request was invalid
//
// The bound parameters must be non-zero and must fit in 5 bits (<= 31).

module bmi_weight_range #(
  parameter int unsigned T_UNDER = 18,
  parameter int unsigned T_OVER  = 25,
  parameter int unsigned T_OBESE = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] height,
  input  logic [7:0] category,
  output logic       busy,
  output logic       done,
  output logic [7:0] w_min,
  output logic [7:0] w_max,
  output logic       range_ok,
  output logic       error
);

  // 31 * 255^2 < 2^21, so no product can overflow before saturation.
  localparam int unsigned PW = 21;

  localparam logic [4:0] BoundUnder = 5'(T_UNDER);
  localparam logic [4:0] BoundOver  = 5'(T_OVER);
  localparam logic [4:0] BoundObese = 5'(T_OBESE);

  localparam logic [PW-1:0] Sat = PW'(255);

  typedef enum logic [2:0] {
    StIdle,
    StSqr,
    StMlo,
    StMhi,
    StDone
  } state_e;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic [1:0]    cat_q;
  logic [15:0]   sq_q;
  logic [PW-1:0] mcand_q;
  logic [7:0]    mplier_q;
  logic [PW-1:0] acc_q;
  logic [PW-1:0] lo_prod_q;

  logic          busy_q;
  logic          done_q;
  logic [7:0]    w_min_q;
  logic [7:0]    w_max_q;
  logic          range_ok_q;
  logic          error_q;

  logic [PW-1:0] acc_step;
  logic [4:0]    lo_c;
  logic [4:0]    hi_c;
  logic          req_invalid;
  logic [PW-1:0] hi_m1;
  logic [7:0]    res_min;
  logic [7:0]    res_max;
  logic          res_ok;

  // One shift-add iteration: add the multiplicand when the current
  // multiplier LSB is set.
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Category bounds. hi for obese is unbounded. The MHI pass still runs so
  // that the latency does not depend on the category. Its product is ignored.
  always_comb begin
    lo_c = 5'd0;
    hi_c = BoundUnder;
    case (cat_q)
      2'd0: begin
        lo_c = 5'd0;
        hi_c = BoundUnder;
      end
      2'd1: begin
        lo_c = BoundUnder;
        hi_c = BoundOver;
      end
      2'd2: begin
        lo_c = BoundOver;
        hi_c = BoundObese;
      end
      default: begin
        lo_c = BoundObese;
        hi_c = BoundObese;
      end
    endcase
  end

  always_comb begin
    req_invalid = (height == 8'd0) || (category > 8'd3);
  end

  // Result formation during the last MHI iteration. acc_step holds hi*h^2
  // at that point.
  always_comb begin
    hi_m1   = acc_step - PW'(1);
    res_min = 8'd255;
    res_max = 8'd255;
    res_ok  = 1'b0;

    if (lo_prod_q <= Sat) begin
      res_ok  = 1'b1;
      res_min = lo_prod_q[7:0];

      if (cat_q == 2'd3) begin
        res_max = 8'd255;
      end else if (hi_m1 > Sat) begin
        res_max = 8'd255;
      end else begin
        res_max = hi_m1[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cat_q      <= '0;
      sq_q       <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      lo_prod_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      w_min_q    <= '0;
      w_max_q    <= '0;
      range_ok_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      busy_q <= (state_q == StSqr) || (state_q == StMlo) || (state_q == StMhi);
      done_q <= (state_q == StDone);

      case (state_q)
        StIdle: begin
          if (start) begin
            if (req_invalid) begin
              w_min_q    <= '0;
              w_max_q    <= '0;
              range_ok_q <= 1'b0;
              error_q    <= 1'b1;
              state_q    <= StDone;
            end else begin
              cat_q    <= category[1:0];
              mcand_q  <= PW'(height);
              mplier_q <= height;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= StSqr;
            end
          end
        end

        StSqr: begin
          if (cnt_q == 3'd7) begin
            sq_q     <= acc_step[15:0];
            mcand_q  <= acc_step;
            mplier_q <= {3'b000, lo_c};
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= StMlo;
          end else begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 3'd1;
          end
        end

        StMlo: begin
          if (cnt_q == 3'd4) begin
            lo_prod_q <= acc_step;
            mcand_q   <= PW'(sq_q);
            mplier_q  <= {3'b000, hi_c};
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= StMhi;
          end else begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 3'd1;
          end
        end

        StMhi: begin
          if (cnt_q == 3'd4) begin
            w_min_q    <= res_min;
            w_max_q    <= res_max;
            range_ok_q <= res_ok;
            error_q    <= 1'b0;
            cnt_q      <= '0;
            state_q    <= StDone;
          end else begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 3'd1;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign w_min    = w_min_q;
  assign w_max    = w_max_q;
  assign range_ok = range_ok_q;
  assign error    = error_q;

endmodule

// File: doc/bmi_weight_range.md
BMI_WEIGHT_RANGE -- requirements
Module: bmi_weight_range

Interface
REQ-001 SHALL: parameter T_UNDER, default 18, lower integer BMI bound of category 1 (normal).
REQ-002 SHALL: parameter T_OVER, default 25, lower integer BMI bound of category 2 (overweight).
REQ-003 SHALL: parameter T_OBESE, default 30, lower integer BMI bound of category 3 (obese).
REQ-004 SHALL: clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL: start  input  1  request pulse; sampled only in IDLE.
REQ-007 SHALL: height  input  8  height in integer metres, unsigned.
REQ-008 SHALL: category  input  8  category code: 0 underweight, 1 normal, 2 overweight, 3 obese; 4..255 invalid.
REQ-009 SHALL: busy  output  1  high from the edge after start is accepted until done is high.
REQ-010 SHALL: done  output  1  one-cycle completion pulse.
REQ-011 SHALL: w_min  output  8  smallest weight (kg) in the requested category, saturated to 255.
REQ-012 SHALL: w_max  output  8  largest weight (kg) in the requested category, saturated to 255.
REQ-013 SHALL: range_ok  output  1  high when the saturated range is non-empty, i.e. unsaturated w_min <= 255.
REQ-014 SHALL: error  output  1  high when the request was invalid (height 0 or category > 3).

Function
REQ-015 SHALL: category definition is floor-free: weight w is in category c iff lo(c)*h^2 <= w < hi(c)*h^2; lo = {0, T_UNDER, T_OVER, T_OBESE}, hi = {T_UNDER, T_OVER, T_OBESE, infinity}.
REQ-016 SHALL: results are w_min = lo(c)*h^2 and w_max = hi(c)*h^2 - 1 (255 for c=3), each saturated to 255; internal products at least 21 bits wide, no truncation before saturation.
REQ-017 SHALL: FSM states are IDLE, SQR, MLO, MHI, DONE.
REQ-018 SHALL: in IDLE, start=1 at an edge latches height and category and goes to SQR; if the request is invalid, it goes directly to DONE instead.
REQ-019 SHALL: SQR computes h^2 by shift-add in exactly 8 cycles; MLO computes lo*h^2 in exactly 5 cycles; MHI computes hi*h^2 in exactly 5 cycles; then DONE.
REQ-020 SHALL: a valid request gives done=1 in the cycle beginning 19 edges after the accepting edge; an invalid request gives done=1 one edge after the accepting edge.
REQ-021 SHALL: DONE lasts exactly one cycle and then returns to IDLE; start is sampled again from the next IDLE cycle.
REQ-022 SHALL: w_min, w_max, range_ok and error update only on the edge entering DONE, and hold until the next DONE.
REQ-023 SHALL: when range_ok=0, w_min = w_max = 255.
REQ-024 SHALL: on an invalid request, error=1, range_ok=0, and w_min = w_max = 0.
REQ-025 SHALL: start while busy is ignored (no queueing); changes to height and category after acceptance do not affect the result.
REQ-026 SHALL: busy and done are never high in the same cycle.

Reset
REQ-027 SHALL: rst_n=0 forces IDLE immediately, with busy, done, w_min, w_max, range_ok and error all 0.
REQ-028 SHALL: reset during SQR, MLO or MHI aborts the request: no done pulse, and outputs stay at reset values until a new request completes.
REQ-029 SHALL: after rst_n deasserts, the first rising edge with start=1 is accepted.

Verification
REQ-030 SHALL: height=2, category=1, start pulse -> done after 19 cycles, w_min=72, w_max=99, range_ok=1, error=0 (weight 80 lies inside).
REQ-031 SHALL: height=2, category=3 -> w_min=120, w_max=255, range_ok=1; height=3, category=0 -> w_min=0, w_max=161, range_ok=1.
REQ-032 SHALL: height=3, category=2 -> w_min=225, w_max=255 (saturated from 269), range_ok=1; height=4, category=2 -> range_ok=0, w_min=w_max=255.
REQ-033 SHALL: height=0 or category=7 -> done one cycle after start, error=1, range_ok=0, w_min=w_max=0.
REQ-034 SHALL: a second start and changed inputs during busy -> ignored, and the first result is unchanged; rst_n pulsed low mid-MLO -> no done, all outputs 0.
REQ-035 SHALL: back-to-back requests, each start issued in the first IDLE cycle after done -> each result is correct and each done is exactly one cycle wide.
